// File: rtl/unique0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : unique0_pkg
// Description : Shared definitions for the unique0 decision-chain checker:
//               arm index constants, the arm vector type and a 3-bit
//               population count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package unique0_pkg;

    // Bit positions of each arm in match_vec / sel, in priority order.
    localparam int ARM_EQ  = 0;   // A == B
    localparam int ARM_LT  = 1;   // A <  B
    localparam int ARM_LTT = 2;   // A <  THRESH

    typedef logic [2:0] arm_vec_t;

    // Number of arms whose condition is true.
    function automatic logic [1:0] popcnt3(input arm_vec_t v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage : unique0_pkg
`default_nettype wire

// File: rtl/unique0_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : unique0_checker_if
// Description : Sample/result bus of the unique0 checker.
//               master : drives in_valid, a, b; observes the registered result
//               slave  : the checker; consumes the sample, drives the result
//               Signals: in_valid, a[W-1:0], b[W-1:0] (sample side)
//                        out_valid, match_vec[2:0], sel[2:0], overlap, none
// Revision    : 1.0 - initial release
// ============================================================================
interface unique0_checker_if #(
    parameter int W = 32
);
    import unique0_pkg::*;

    logic           in_valid;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    arm_vec_t       match_vec;
    arm_vec_t       sel;
    logic           overlap;
    logic           none;

    modport master (
        output in_valid, a, b,
        input  out_valid, match_vec, sel, overlap, none
    );

    modport slave (
        input  in_valid, a, b,
        output out_valid, match_vec, sel, overlap, none
    );

endinterface : unique0_checker_if
`default_nettype wire

// File: rtl/u0_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : u0_sat_counter
// Description : CW-bit event counter that saturates at all-ones and never
//               wraps. clr has priority over inc.
//               Ports: clk, rst (async, active high), inc, clr, count[CW-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module u0_sat_counter #(
    parameter int CW = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          inc,
    input  wire logic          clr,
    output logic [CW-1:0]      count
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule : u0_sat_counter
`default_nettype wire

// File: rtl/unique0_checker.sv
`default_nettype none
// ============================================================================
// Module      : unique0_checker
// Description : Registered run-time checker for a three-arm if/else-if chain
//               with unique0 semantics. Per valid sample it evaluates
//               arm0 A==B, arm1 A<B, arm2 A<THRESH (all signed), reports the
//               first true arm, flags overlap (>1 arm true) and no-match,
//               and keeps saturating statistics.
//               Ports: clk, rst (async, active high), bus (slave modport:
//                      in_valid/a/b in, out_valid/match_vec/sel/overlap/none
//                      out), clr, overlap_sticky, sample_cnt, overlap_cnt,
//                      none_cnt
// Revision    : 1.0 - initial release
// ============================================================================
module unique0_checker
    import unique0_pkg::*;
#(
    parameter int                    W      = 32,
    parameter logic signed [W-1:0]   THRESH = 20,
    parameter int                    CW     = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    unique0_checker_if.slave     bus,
    input  wire logic            clr,
    output logic                 overlap_sticky,
    output logic [CW-1:0]        sample_cnt,
    output logic [CW-1:0]        overlap_cnt,
    output logic [CW-1:0]        none_cnt
);

    logic signed [W-1:0] a_s;
    logic signed [W-1:0] b_s;

    arm_vec_t match_now;
    arm_vec_t sel_now;
    logic     overlap_now;
    logic     none_now;

    logic     out_valid_q, out_valid_d;
    arm_vec_t match_q,     match_d;
    arm_vec_t sel_q,       sel_d;
    logic     overlap_q,   overlap_d;
    logic     none_q,      none_d;
    logic     sticky_q,    sticky_d;

    // Reinterpret the bus operands as two's-complement so all compares are signed.
    assign a_s = bus.a;
    assign b_s = bus.b;

    // Condition evaluation and priority select for the current sample.
    always_comb begin
        match_now          = '0;
        match_now[ARM_EQ]  = (a_s == b_s);
        match_now[ARM_LT]  = (a_s <  b_s);
        match_now[ARM_LTT] = (a_s <  THRESH);

        sel_now = '0;
        if (match_now[ARM_EQ]) begin
            sel_now[ARM_EQ] = 1'b1;
        end else if (match_now[ARM_LT]) begin
            sel_now[ARM_LT] = 1'b1;
        end else if (match_now[ARM_LTT]) begin
            sel_now[ARM_LTT] = 1'b1;
        end

        overlap_now = (popcnt3(match_now) > 2'd1);
        none_now    = (match_now == '0);
    end

    // Result registers hold their last value between valid samples.
    always_comb begin
        out_valid_d = bus.in_valid;
        match_d     = match_q;
        sel_d       = sel_q;
        overlap_d   = overlap_q;
        none_d      = none_q;
        if (bus.in_valid) begin
            match_d   = match_now;
            sel_d     = sel_now;
            overlap_d = overlap_now;
            none_d    = none_now;
        end

        // clr wins over a same-cycle overlap for the sticky flag.
        if (clr) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q | (bus.in_valid & overlap_now);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            match_q     <= '0;
            sel_q       <= '0;
            overlap_q   <= 1'b0;
            none_q      <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            match_q     <= match_d;
            sel_q       <= sel_d;
            overlap_q   <= overlap_d;
            none_q      <= none_d;
            sticky_q    <= sticky_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.match_vec   = match_q;
    assign bus.sel         = sel_q;
    assign bus.overlap     = overlap_q;
    assign bus.none        = none_q;
    assign overlap_sticky  = sticky_q;

    u0_sat_counter #(.CW(CW)) u_sample_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.in_valid),
        .clr   (clr),
        .count (sample_cnt)
    );

    u0_sat_counter #(.CW(CW)) u_overlap_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.in_valid & overlap_now),
        .clr   (clr),
        .count (overlap_cnt)
    );

    u0_sat_counter #(.CW(CW)) u_none_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.in_valid & none_now),
        .clr   (clr),
        .count (none_cnt)
    );

endmodule : unique0_checker
`default_nettype wire

// File: tb/tb_unique0_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_unique0_checker
// Description : Self-checking bench for unique0_checker. Two instances share
//               one stimulus stream: the default CW=16 build and a CW=4 build
//               that reaches saturation quickly. A behavioural model derives
//               every expected value from the arm rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unique0_checker;
    import unique0_pkg::*;

    localparam int THR = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    unique0_checker_if #(.W(32)) bus16 ();
    unique0_checker_if #(.W(32)) bus4 ();

    logic        sticky16, sticky4;
    logic [15:0] samp16, ov16, none16;
    logic [3:0]  samp4, ov4, none4;

    unique0_checker #(.W(32), .THRESH(THR), .CW(16)) u_dut16 (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus16.slave),
        .clr            (clr),
        .overlap_sticky (sticky16),
        .sample_cnt     (samp16),
        .overlap_cnt    (ov16),
        .none_cnt       (none16)
    );

    unique0_checker #(.W(32), .THRESH(THR), .CW(4)) u_dut4 (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus4.slave),
        .clr            (clr),
        .overlap_sticky (sticky4),
        .sample_cnt     (samp4),
        .overlap_cnt    (ov4),
        .none_cnt       (none4)
    );

    int total  = 0;
    int passed = 0;

    // Reference model state.
    bit       m_ovalid;
    bit [2:0] m_match, m_sel;
    bit       m_ov, m_none, m_sticky;
    int       m_samp16, m_ov16, m_none16;
    int       m_samp4,  m_ov4,  m_none4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int c, input int inc, input int cw);
        int lim = (1 << cw) - 1;
        return (c + inc > lim) ? lim : c + inc;
    endfunction

    task automatic model_reset();
        m_ovalid = 0; m_match = '0; m_sel = '0; m_ov = 0; m_none = 0; m_sticky = 0;
        m_samp16 = 0; m_ov16 = 0; m_none16 = 0;
        m_samp4  = 0; m_ov4  = 0; m_none4  = 0;
    endtask

    // Applies one sample to the model, directly from the arm rules.
    task automatic model_step(input bit v, input int a, input int b, input bit c);
        bit conds [3];
        int ntrue;
        conds[0] = (a == b);
        conds[1] = (a < b);
        conds[2] = (a < THR);
        ntrue = int'(conds[0]) + int'(conds[1]) + int'(conds[2]);
        m_ovalid = v;
        if (v) begin
            m_match = {conds[2], conds[1], conds[0]};
            m_sel   = '0;
            for (int i = 0; i < 3; i++) begin
                if (conds[i] && m_sel == '0) m_sel[i] = 1'b1;
            end
            m_ov   = (ntrue > 1);
            m_none = (ntrue == 0);
        end
        if (c) begin
            m_sticky = 0;
            m_samp16 = 0; m_ov16 = 0; m_none16 = 0;
            m_samp4  = 0; m_ov4  = 0; m_none4  = 0;
        end else if (v) begin
            m_sticky = m_sticky | m_ov;
            m_samp16 = sat(m_samp16, 1, 16);
            m_ov16   = sat(m_ov16, int'(m_ov), 16);
            m_none16 = sat(m_none16, int'(m_none), 16);
            m_samp4  = sat(m_samp4, 1, 4);
            m_ov4    = sat(m_ov4, int'(m_ov), 4);
            m_none4  = sat(m_none4, int'(m_none), 4);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ovalid16"},  32'(bus16.out_valid), 32'(m_ovalid));
        chk({tag, ".match16"},   32'(bus16.match_vec), 32'(m_match));
        chk({tag, ".sel16"},     32'(bus16.sel),       32'(m_sel));
        chk({tag, ".overlap16"}, 32'(bus16.overlap),   32'(m_ov));
        chk({tag, ".none16"},    32'(bus16.none),      32'(m_none));
        chk({tag, ".sticky16"},  32'(sticky16),        32'(m_sticky));
        chk({tag, ".samp16"},    32'(samp16),          32'(m_samp16));
        chk({tag, ".ovcnt16"},   32'(ov16),            32'(m_ov16));
        chk({tag, ".nonecnt16"}, 32'(none16),          32'(m_none16));
        chk({tag, ".ovalid4"},   32'(bus4.out_valid),  32'(m_ovalid));
        chk({tag, ".match4"},    32'(bus4.match_vec),  32'(m_match));
        chk({tag, ".sel4"},      32'(bus4.sel),        32'(m_sel));
        chk({tag, ".sticky4"},   32'(sticky4),         32'(m_sticky));
        chk({tag, ".samp4"},     32'(samp4),           32'(m_samp4));
        chk({tag, ".ovcnt4"},    32'(ov4),             32'(m_ov4));
        chk({tag, ".nonecnt4"},  32'(none4),           32'(m_none4));
    endtask

    // Drives one cycle of stimulus, lets the edge happen, then checks.
    task automatic step(input string tag, input bit v, input int a, input int b, input bit c);
        bus16.in_valid = v; bus16.a = a; bus16.b = b;
        bus4.in_valid  = v; bus4.a  = a; bus4.b  = b;
        clr = c;
        @(posedge clk);
        #1;
        model_step(v, a, b, c);
        check_all(tag);
    endtask

    initial begin
        int ra, rb;
        bit rv, rc;

        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0;
        bus4.in_valid  = 1'b0; bus4.a  = '0; bus4.b  = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Directed arm patterns.
        step("none",      1, 30, 20, 0);
        step("lt_ltt",    1, 10, 20, 0);
        step("eq_only",   1, 20, 20, 0);
        step("eq_ltt",    1,  5,  5, 0);
        step("idle_hold", 0, 99, -7, 0);
        step("signed_lt", 1, -1,  0, 0);
        step("signed_gt", 1,  0, -1, 0);
        step("max_neg",   1, 32'sh8000_0000, 32'sh7fff_ffff, 0);

        // Overlap burst drives the CW=4 counters into saturation.
        for (int i = 0; i < 20; i++) step("ov_burst", 1, 10, 20, 0);
        chk("ov4_saturated", 32'(ov4), 32'd15);

        // clr together with a sample: counters/sticky clear, result updates.
        step("clr_valid", 1, 30, 20, 1);
        chk("clr_samp16_zero", 32'(samp16), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 3) == 0) begin
                ra = int'($urandom);
                rb = ($urandom_range(0, 3) == 0) ? ra : int'($urandom);
            end else begin
                ra = int'($urandom_range(0, 60)) - 30;
                rb = int'($urandom_range(0, 60)) - 30;
            end
            step("rand", rv, ra, rb, rc);
        end

        // Asynchronous reset mid-stream with a sample in flight.
        step("pre_rst", 1, 10, 20, 0);
        bus16.in_valid = 1'b1; bus4.in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #2;
        rst = 1'b0;
        step("post_rst", 1, 30, 20, 0);
        chk("post_rst_samp", 32'(samp16), 32'd1);
        step("post_rst_idle", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_unique0_checker
`default_nettype wire
